uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered, parametrised UART transmitter for the s4x7 diagnostic/debug serial path. It replaces the single-byte transmit buffer with a FIFO so firmware-side producers can burst several characters without polling per byte. It adds configurable data width, stop-bit count and optional parity. It sits between the diag command/response logic and the FPGA TXD pin, clocked from the 100 MHz system clock.

## Interface
Parameters:
- BAUD_DIV, 867: clocks per bit minus 1 (100 MHz / 115200 → 867 at 115.2k; 1735 at 57.6k); legal 1..8191.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- STOP_BITS, 1: stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; power of two, 2..256.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high; clock clk.
- din  in  DATA_BITS  write data.
- wr_stb  in  1  single-clock write strobe.
- parity_odd  in  1  1 = odd parity, 0 = even; sampled when a frame starts.
- full  out  1  FIFO holds FIFO_DEPTH words.
- level  out  $clog2(FIFO_DEPTH)+1  words in FIFO, excluding the word being shifted.
- tbre  out  1  FIFO empty and shifter idle; line is at mark.
- overflow  out  1  sticky; set by a write while full.
- ovf_clr  in  1  clears overflow.
- txd  out  1  serial output, idle mark (1).

## Operation
- Reset values: txd=1, tbre=1, full=0, level=0, overflow=0. FIFO pointers are zeroed, the FSM is in IDLE and the baud counter is 0.
- Write path:
  - wr_stb with full=0 stores din and increments level on the next edge.
  - wr_stb with full=1 drops the data, leaves level unchanged and sets overflow.
  - overflow set has priority over ovf_clr in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if level≠0, pop the head into the shift register, reload the baud counter to BAUD_DIV, drive txd=0 and go to START.
  - START → DATA after one bit time.
  - DATA: shift out LSB first, DATA_BITS bit times.
  - DATA → PARITY (macro on) or STOP.
  - PARITY: one bit time. Even parity = XOR of data bits; odd parity = its inverse.
  - STOP: txd=1 for STOP_BITS bit times. Then go to IDLE, or start the next frame directly if level≠0.
- Bit time: the baud counter counts down from BAUD_DIV to 0, so each bit is exactly BAUD_DIV+1 clocks. The counter reloads at each bit boundary.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)·(BAUD_DIV+1) clocks, where P = 1 with parity, else 0.
- tbre = (level==0) && state==IDLE.
- Simultaneous write and pop (full=0): level unchanged, data accepted. A write while full is dropped even if a pop occurs the same cycle, because full is registered.
- Pointers wrap modulo FIFO_DEPTH. level saturates by construction at FIFO_DEPTH.

## Timing
- A write at edge N into an empty, idle block gives level=1 after N. The pop occurs at N+1, and txd falls at N+1, registered, visible after edge N+1.
- tbre falls after edge N, the same edge level rises.
- Back-to-back frames have no idle gap beyond the STOP bits. The next start bit begins on the clock following the last stop-bit clock.
- tbre rises one clock after the final stop bit time ends, provided level=0.
- Reset mid-frame: txd returns to 1 on the next edge and queued data is discarded. This produces a truncated frame on the line, which is accepted behaviour.
- parity_odd changes during a frame do not affect the frame in progress.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is present and parity_odd selects the sense.
- UART_TX_PARITY_EN undefined: no parity bit is sent, parity_odd is ignored, the PARITY state and XOR logic are absent, and P=0.

## Test plan
Bench settings: BAUD_DIV=3, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4.
- Reset then idle 50 clocks → txd=1, tbre=1, level=0, overflow=0 throughout.
- Write 0xA5 → txd: 0 for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then 1. Frame is 40 clocks without parity; tbre=1 one clock after.
- Parity build, parity_odd=0, write 0x07 → parity bit 1. With parity_odd=1 → parity bit 0. Frame is 44 clocks.
- Write 6 words on consecutive clocks (0x01..0x06) → the first is popped immediately, 4 are queued, the 6th is dropped with overflow=1. Output is 0x01..0x05 back-to-back with no gap. ovf_clr then clears overflow.
- Assert rst mid-DATA of 0x55 with 2 words queued → txd=1 next clock, level=0, tbre=1, and no further frames.
- STOP_BITS=2, DATA_BITS=7, write 0x7F → 1 start, 7 ones, 2 stop bits: 40 clocks, low only during the start bit.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to send a parity bit (sense from parity_odd).
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 867,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        din,
    input  logic                        wr_stb,
    input  logic                        parity_odd,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        tbre,
    output logic                        overflow,
    input  logic                        ovf_clr,
    output logic                        txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state, state_nxt;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [DATA_BITS-1:0] shreg;
    logic [CW-1:0]        cnt;
    logic [3:0]           bcnt;
    logic                 sidx;
    logic                 tick, last_data, last_stop;
    logic                 avail, wr_ok, pop;
    logic                 txd_nxt;
    logic                 pbit;

`ifdef UART_TX_PARITY_EN
    logic par;
    assign pbit = par;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign pbit = 1'b1;
`endif

    assign avail     = (level != '0);
    assign full      = (level == FULL_LVL);
    assign wr_ok     = wr_stb && !full;
    assign tbre      = !avail && (state == IDLE);
    assign tick      = (state != IDLE) && (cnt == '0);
    assign last_data = (bcnt == 4'(DATA_BITS - 1));
    assign last_stop = (STOP_BITS == 1) || sidx;

    // FIFO storage array; no reset needed, level gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= din;
    end

    // FIFO pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow; a dropped write wins over a clear.
    always_ff @(posedge clk) begin
        if (rst)                 overflow <= 1'b0;
        else if (wr_stb && full) overflow <= 1'b1;
        else if (ovf_clr)        overflow <= 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic; STOP chains straight into START when data waits.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (avail) state_nxt = START;
            START:  if (tick) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (tick && last_data) state_nxt = PARITY;
            PARITY: if (tick) state_nxt = STOP;
`else
            DATA:   if (tick && last_data) state_nxt = STOP;
`endif
            STOP:   if (tick && last_stop) state_nxt = avail ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: FIFO pop and the next line level at each bit boundary.
    always_comb begin
        pop     = 1'b0;
        txd_nxt = txd;
        unique case (state)
            IDLE: if (avail) begin
                pop     = 1'b1;
                txd_nxt = 1'b0;
            end
            START:  if (tick) txd_nxt = shreg[0];
            DATA:   if (tick) txd_nxt = last_data ? pbit : shreg[1];
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) txd_nxt = 1'b1;
`endif
            STOP: if (tick && last_stop && avail) begin
                pop     = 1'b1;
                txd_nxt = 1'b0;
            end
            default: txd_nxt = 1'b1;
        endcase
    end

    // Datapath: registered line, baud counter, shifter and bit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd   <= 1'b1;
            cnt   <= '0;
            shreg <= '0;
            bcnt  <= '0;
            sidx  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            txd <= txd_nxt;
            if (pop) begin
                shreg <= mem[rptr];
                cnt   <= RELOAD;
`ifdef UART_TX_PARITY_EN
                par   <= (^mem[rptr]) ^ parity_odd;
`endif
            end else if (tick) begin
                cnt <= (state_nxt == IDLE) ? '0 : RELOAD;
            end else if (state != IDLE) begin
                cnt <= cnt - 1'b1;
            end
            if (state == START && tick) bcnt <= '0;
            if (state == DATA && tick) begin
                bcnt  <= bcnt + 1'b1;
                shreg <= shreg >> 1;
            end
            if (state_nxt == STOP && state != STOP) sidx <= 1'b0;
            else if (state == STOP && tick)         sidx <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; a line monitor decodes txd frames
// and compares them against bytes queued when each write is issued.
module tb_uart_tx_fifo;
    localparam int BD = 3;
    localparam int NB = 8;
    localparam int BT = BD + 1;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FR0 = (1 + NB + P + 1) * BT;
    localparam int FR1 = (1 + 7 + P + 2) * BT;

    logic       clk;
    logic       rst;
    logic [7:0] din0;
    logic       wr0, po, clr;
    logic       full0, tbre0, ovf0, txd0;
    logic [2:0] level0;
    logic [6:0] din1;
    logic       wr1, po1, clr1;
    logic       full1, tbre1, ovf1, txd1;
    logic [2:0] level1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(NB), .STOP_BITS(1),
                   .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .din(din0), .wr_stb(wr0),
        .parity_odd(po), .full(full0), .level(level0), .tbre(tbre0),
        .overflow(ovf0), .ovf_clr(clr), .txd(txd0)
    );

    uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(7), .STOP_BITS(2),
                   .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .din(din1), .wr_stb(wr1),
        .parity_odd(po1), .full(full1), .level(level1), .tbre(tbre1),
        .overflow(ovf1), .ovf_clr(clr1), .txd(txd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    int exp_q[$];
    int st_q[$];
    int mk;
    bit mbusy = 0;
    logic [8:0] msh;

    // Line monitor: samples mid-bit, pops the scoreboard at the stop bit.
    always @(negedge clk) begin
        if (rst) begin
            mbusy = 0;
        end else if (!mbusy) begin
            if (txd0 === 1'b0) begin
                mbusy = 1;
                mk = 0;
                msh = '0;
                st_q.push_back(cyc);
            end
        end else begin
            mk++;
            if (mk == 2) begin
                chk("start_bit", 32'(txd0), 0);
            end else if (mk >= BT + 2 && mk <= BT * NB + 2 &&
                         (mk - 2) % BT == 0) begin
                msh[(mk - 2) / BT - 1] = txd0;
            end else if (P == 1 && mk == BT * (NB + 1) + 2) begin
                msh[8] = txd0;
            end else if (mk == BT * (NB + 1 + P) + 2) begin
                chk("stop_bit", 32'(txd0), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame got %0h want none", msh);
                end else begin
                    chk("frame", 32'(msh), 32'(exp_q.pop_front()));
                end
            end
            if (mk == FR0 - 1) mbusy = 0;
        end
    end

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        din0 = d;
        wr0 = 1'b1;
        @(negedge clk);
        wr0 = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(tbre0 && exp_q.size() == 0 && !mbusy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(n < 1000), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        din0 = '0; wr0 = 0; po = 0; clr = 0;
        din1 = '0; wr1 = 0; po1 = 0; clr1 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_txd", 32'(txd0), 1);
            chk("idle_tbre", 32'(tbre0), 1);
            chk("idle_level", 32'(level0), 0);
            chk("idle_ovf", 32'(ovf0), 0);
        end

        // single frame 0xA5: even parity of A5 is 0
        exp_q.push_back(32'h0A5);
        wr(8'hA5);
        chk("a5_level", 32'(level0), 1);
        chk("a5_tbre_fall", 32'(tbre0), 0);
        chk("a5_txd_pre", 32'(txd0), 1);
        @(negedge clk);
        chk("a5_txd_start", 32'(txd0), 0);
        chk("a5_level_pop", 32'(level0), 0);
        repeat (FR0 - 1) @(negedge clk);
        chk("a5_last_stop_txd", 32'(txd0), 1);
        chk("a5_last_stop_tbre", 32'(tbre0), 0);
        @(negedge clk);
        chk("a5_tbre_rise", 32'(tbre0), 1);
        wait_idle("a5_done");

`ifdef UART_TX_PARITY_EN
        po = 1'b0;
        exp_q.push_back(32'h107);
        wr(8'h07);
        wait_idle("par_even");
        po = 1'b1;
        exp_q.push_back(32'h007);
        wr(8'h07);
        repeat (10) @(negedge clk);
        po = 1'b0;
        wait_idle("par_odd");
`endif

        // burst of six into a 4-deep FIFO: 0x06 is dropped
        st_q.delete();
        exp_q.push_back(P ? 32'h101 : 32'h01);
        exp_q.push_back(P ? 32'h102 : 32'h02);
        exp_q.push_back(32'h03);
        exp_q.push_back(P ? 32'h104 : 32'h04);
        exp_q.push_back(32'h05);
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            din0 = 8'(i);
            wr0 = 1'b1;
            @(negedge clk);
        end
        wr0 = 1'b0;
        chk("burst_level", 32'(level0), 4);
        chk("burst_full", 32'(full0), 1);
        chk("burst_ovf", 32'(ovf0), 1);
        wait_idle("burst_done");
        chk("burst_frames", 32'(st_q.size()), 5);
        for (int i = 1; i < st_q.size(); i++)
            chk("burst_gap", 32'(st_q[i] - st_q[i-1]), 32'(FR0));
        chk("ovf_sticky", 32'(ovf0), 1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ovf_clr", 32'(ovf0), 0);

        // reset mid-DATA of 0x55 with two words queued
        @(negedge clk);
        din0 = 8'h55; wr0 = 1'b1;
        @(negedge clk);
        din0 = 8'h11;
        @(negedge clk);
        din0 = 8'h22;
        @(negedge clk);
        wr0 = 1'b0;
        repeat (16) @(negedge clk);
        chk("rst_pre_level", 32'(level0), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_txd", 32'(txd0), 1);
        chk("rst_level", 32'(level0), 0);
        chk("rst_tbre", 32'(tbre0), 1);
        chk("rst_ovf", 32'(ovf0), 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("post_rst_txd", 32'(txd0), 1);
            chk("post_rst_tbre", 32'(tbre0), 1);
        end

        // 7 data bits, 2 stop bits, 0x7F: low only in the start bit
        @(negedge clk);
        din1 = 7'h7F;
        wr1 = 1'b1;
        @(negedge clk);
        wr1 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < FR1; k++) begin
            chk("u1_txd", 32'(txd1), 32'(k >= BT));
            if (k == FR1 - 1) chk("u1_tbre_busy", 32'(tbre1), 0);
            @(negedge clk);
        end
        chk("u1_tbre", 32'(tbre1), 1);
        chk("u1_level", 32'(level1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
